digit_serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor. Adds two WIDTH-bit operands DIGIT bits per clock and carries the result between digits in a register. Built as the sequential successor to the single-bit combinational full adder: its per-digit datapath is a DIGIT-bit ripple chain of full adders. Used where a wide adder must trade latency for area; a start/busy/done handshake sequences each operation.

---
 rtl/digit_serial_adder_pkg.sv | 17 +
 rtl/digit_serial_adder_slice.sv | 39 +++
 rtl/digit_serial_adder.sv | 110 +++++++++++
 tb/tb_digit_serial_adder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Digit counter width; a one-digit operation still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/digit_serial_adder_slice.sv
// One-bit full adder and the DIGIT-bit ripple slice built from it.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);
    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: processes DIGIT bits per clock, carry held in a register.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [DIGIT-1:0] s_dig;
    logic             s_cout;
    logic             s_cmsb;

    // Operands shift right each digit, so the active digit is always the low slice.
    adder_slice #(.DIGIT(DIGIT)) u_slice (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .cin   (carry),
        .s     (s_dig),
        .cout  (s_cout),
        .c_msb (s_cmsb)
    );

    // Result digits enter at the top and shift down; after N digits they sit in place.
    if (N == 1) begin : g_single
        assign acc_next = s_dig;
    end else begin : g_multi
        assign acc_next = {s_dig, acc[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub | cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    acc   <= acc_next;
                    carry <= s_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        sum   <= acc_next;
                        cout  <= s_cout;
                        ovf   <= s_cmsb ^ s_cout;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: an 8/2 instance and an 8/8 instance against an arithmetic model.
module tb_digit_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start0 = 1'b0;
    logic         start1 = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy0, done0, cout0, ovf0;
    logic         busy1, done1, cout1, ovf1;
    logic [W-1:0] sum0, sum1;

    int           total = 0;
    int           bad = 0;
    logic [W-1:0] last0 = '0;
    logic [W-1:0] last1 = '0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst(rst), .start(start0), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    // Returns {cout, ovf, sum} from whole-word arithmetic and sign rules.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, mb, input logic mcin, msub);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         c0;
        logic         v;
        bb   = msub ? ~mb : mb;
        c0   = msub ? 1'b1 : mcin;
        full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, c0};
        v    = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        return {full[W], v, full[W-1:0]};
    endfunction

    // Runs one operation on the selected instance and records what it observed.
    task automatic do_op(input bit sel, input logic [W-1:0] oa, ob, input logic ocin, osub,
                         input logic [W-1:0] prev, output logic [W+1:0] res,
                         output int lat, output int busy_n, output int done_n, output bit held);
        int n;
        n = sel ? 1 : 4;
        res = 'x; lat = -1; busy_n = 0; done_n = 0; held = 1'b1;
        @(negedge clk);
        a = oa; b = ob; cin = ocin; sub = osub;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0; start1 = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        for (int e = 0; e < n + 4; e++) begin
            @(negedge clk);
            if (sel ? busy1 : busy0) busy_n++;
            if (sel ? done1 : done0) begin
                done_n++;
                lat = e;
                res = sel ? {cout1, ovf1, sum1} : {cout0, ovf0, sum0};
            end
            if (e < n && (sel ? sum1 : sum0) !== prev) held = 1'b0;
            @(posedge clk);
            #1;
            cin = ~cin;
            a = W'($urandom);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy0, done0, cout0, ovf0, sum0} !== '0) begin
            bad++;
            $display("FAIL reset_dut: got busy=%b done=%b cout=%b ovf=%b sum=%h want all 0",
                     busy0, done0, cout0, ovf0, sum0);
        end
        total++;
        if ({busy1, done1, cout1, ovf1, sum1} !== '0) begin
            bad++;
            $display("FAIL reset_dut1: got busy=%b done=%b cout=%b ovf=%b sum=%h want all 0",
                     busy1, done1, cout1, ovf1, sum1);
        end
        rst = 1'b0;
    endtask

    typedef struct packed {
        bit           sel;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic         vsub;
        logic [W-1:0] esum;
        logic         ecout;
        logic         eovf;
    } vec_t;

    task automatic test_directed;
        vec_t        vecs[6];
        logic [W+1:0] res;
        int          lat, busy_n, done_n, n;
        bit          held;
        vecs[0] = '{1'b0, 8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        foreach (vecs[i]) begin
            n = vecs[i].sel ? 1 : 4;
            do_op(vecs[i].sel, vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
                  vecs[i].sel ? last1 : last0, res, lat, busy_n, done_n, held);
            total++;
            if (res !== {vecs[i].ecout, vecs[i].eovf, vecs[i].esum}) begin
                bad++;
                $display("FAIL directed_result[%0d]: got cout=%b ovf=%b sum=%h want cout=%b ovf=%b sum=%h",
                         i, res[W+1], res[W], res[W-1:0], vecs[i].ecout, vecs[i].eovf, vecs[i].esum);
            end
            total++;
            if (lat !== n) begin
                bad++;
                $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, n);
            end
            total++;
            if (busy_n !== n + 1) begin
                bad++;
                $display("FAIL directed_busy_cycles[%0d]: got %0d want %0d", i, busy_n, n + 1);
            end
            total++;
            if (done_n !== 1) begin
                bad++;
                $display("FAIL directed_done_count[%0d]: got %0d want 1", i, done_n);
            end
            total++;
            if (held !== 1'b1) begin
                bad++;
                $display("FAIL directed_sum_held[%0d]: got sum changed before done want held", i);
            end
            total++;
            if ((vecs[i].sel ? sum1 : sum0) !== vecs[i].esum) begin
                bad++;
                $display("FAIL directed_idle_hold[%0d]: got %h want %h", i,
                         vecs[i].sel ? sum1 : sum0, vecs[i].esum);
            end
            if (vecs[i].sel) last1 = vecs[i].esum; else last0 = vecs[i].esum;
        end
    endtask

    task automatic test_random;
        logic [W+1:0] res, exp_r;
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        int           lat, busy_n, done_n;
        bit           held, sel;
        for (int i = 0; i < 20; i++) begin
            sel = (i >= 12);
            ra = W'($urandom); rb = W'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            exp_r = model(ra, rb, rc, rs);
            do_op(sel, ra, rb, rc, rs, sel ? last1 : last0, res, lat, busy_n, done_n, held);
            total++;
            if (res !== exp_r || done_n !== 1 || lat !== (sel ? 1 : 4)) begin
                bad++;
                $display("FAIL random_op[%0d]: got res=%h lat=%0d dones=%0d want res=%h lat=%0d dones=1 (a=%h b=%h cin=%b sub=%b)",
                         i, res, lat, done_n, exp_r, sel ? 1 : 4, ra, rb, rc, rs);
            end
            if (sel) last1 = exp_r[W-1:0]; else last0 = exp_r[W-1:0];
        end
    endtask

    task automatic test_back_to_back;
        logic [W+1:0] exp_q[$];
        int           exp_e[$];
        logic [W+1:0] exp_r;
        logic [W-1:0] ca, cb;
        logic         cc, cs, cst;
        int           next_acc, dones;
        next_acc = 0;
        dones = 0;
        @(negedge clk);
        start0 = 1'b1;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        for (int e = 0; e < 26; e++) begin
            ca = a; cb = b; cc = cin; cs = sub; cst = start0;
            @(posedge clk);
            if (cst && e >= next_acc) begin
                exp_q.push_back(model(ca, cb, cc, cs));
                exp_e.push_back(e + 4);
                next_acc = e + 6;
            end
            @(negedge clk);
            if (done0) begin
                dones++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra_done: got done at edge %0d want none", e);
                end else begin
                    exp_r = exp_q.pop_front();
                    if ({cout0, ovf0, sum0} !== exp_r || exp_e[0] !== e) begin
                        bad++;
                        $display("FAIL b2b_result: got res=%h edge=%0d want res=%h edge=%0d",
                                 {cout0, ovf0, sum0}, e, exp_r, exp_e[0]);
                    end
                    void'(exp_e.pop_front());
                end
            end else if (exp_e.size() > 0 && exp_e[0] == e) begin
                total++;
                bad++;
                $display("FAIL b2b_missing_done: got done=0 at edge %0d want 1", e);
                void'(exp_e.pop_front());
                void'(exp_q.pop_front());
            end
            start0 = (e + 1 <= 18);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        end
        start0 = 1'b0;
        total++;
        if (dones !== 4) begin
            bad++;
            $display("FAIL b2b_done_count: got %0d want 4", dones);
        end
    endtask

    task automatic test_reset_mid;
        logic [W+1:0] res, exp_r;
        int           lat, busy_n, done_n, stray;
        bit           held;
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy0, done0, cout0, ovf0, sum0} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b cout=%b ovf=%b sum=%h want all 0",
                     busy0, done0, cout0, ovf0, sum0);
        end
        rst = 1'b0;
        last0 = '0;
        last1 = '0;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (done0 || busy0) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++;
            $display("FAIL reset_mid_no_done: got %0d busy/done cycles want 0", stray);
        end
        exp_r = model(8'hC3, 8'h5A, 1'b1, 1'b0);
        do_op(1'b0, 8'hC3, 8'h5A, 1'b1, 1'b0, last0, res, lat, busy_n, done_n, held);
        total++;
        if (res !== exp_r || lat !== 4 || done_n !== 1 || held !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_restart: got res=%h lat=%0d dones=%0d held=%b want res=%h lat=4 dones=1 held=1",
                     res, lat, done_n, held, exp_r);
        end
        last0 = exp_r[W-1:0];
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
